// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - ADD/SUB/MUL sequencer driving an external 8-bit ripple adder
// Optional shift-add multiply is included when CALC_MUL_EN is defined.
module calc_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 overflow,
    output logic                 zero,
    output logic                 err
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
`ifdef CALC_MUL_EN
    localparam logic [1:0] OP_MUL = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
`ifdef CALC_MUL_EN
        S_MUL,
`endif
        S_DONE
    } state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_carry;
    logic                 r_overflow;
    logic                 r_zero;
    logic                 r_err;
    logic                 r_out_valid;

`ifdef CALC_MUL_EN
    logic [WIDTH-1:0]     r_p;
    logic [WIDTH-1:0]     r_q;
    logic [2:0]           r_cnt;
    logic [2*WIDTH-1:0]   w_pq_next;
`endif

    logic [WIDTH-1:0]     w_add_a;
    logic [WIDTH-1:0]     w_add_b;
    logic                 w_add_cin;
    logic                 w_ovf;

    // Adder operands are a pure function of the registered state so the
    // external adder's sum can be consumed in the same cycle.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            S_EXEC: begin
                if (r_op == OP_ADD) begin
                    w_add_a = r_opa;
                    w_add_b = r_opb;
                end else if (r_op == OP_SUB) begin
                    w_add_a   = r_opa;
                    w_add_b   = ~r_opb;
                    w_add_cin = 1'b1;
                end
            end
`ifdef CALC_MUL_EN
            S_MUL: begin
                w_add_a = r_p;
                w_add_b = r_q[0] ? r_opa : '0;
            end
`endif
            default: ;
        endcase
    end

    assign w_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != w_add_a[WIDTH-1]);

`ifdef CALC_MUL_EN
    assign w_pq_next = {add_cout, add_sum, r_q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef CALC_MUL_EN
            r_p         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= op;
                        r_opa   <= opa;
                        r_opb   <= opb;
                        r_state <= S_EXEC;
`ifdef CALC_MUL_EN
                        r_p   <= '0;
                        r_q   <= opb;
                        r_cnt <= '0;
                        if (op == OP_MUL) begin
                            r_state <= S_MUL;
                        end
`endif
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_ADD || r_op == OP_SUB) begin
                        r_result   <= {{WIDTH{1'b0}}, add_sum};
                        r_carry    <= add_cout;
                        r_overflow <= w_ovf;
                        r_zero     <= (add_sum == '0);
                        r_err      <= 1'b0;
                    end else begin
                        r_result   <= '0;
                        r_carry    <= 1'b0;
                        r_overflow <= 1'b0;
                        r_zero     <= 1'b1;
                        r_err      <= 1'b1;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
`ifdef CALC_MUL_EN
                S_MUL: begin
                    {r_p, r_q} <= w_pq_next;
                    r_cnt      <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_result    <= w_pq_next;
                        r_carry     <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_zero      <= (w_pq_next == '0);
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign add_a     = w_add_a;
    assign add_b     = w_add_b;
    assign add_cin   = w_add_cin;
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign err       = r_err;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - randomized self-checking bench for calc_op_sequencer
// Expectations follow CALC_MUL_EN the same way the design build does.
module tb_calc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [7:0]  opa = 8'h00;
    logic [7:0]  opb = 8'h00;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // External ripple adder stand-in
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    calc_op_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {err, zero, overflow, carry, result[15:0]}
    function automatic logic [19:0] model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int s;
        logic [15:0] r = 16'h0;
        logic c = 1'b0, v = 1'b0, z = 1'b1, e = 1'b0;
        if (o == 2'b00) begin
            r = 16'((ua + ub) % 256);
            c = (ua + ub) > 255;
            s = sa + sb;
            v = (s > 127) || (s < -128);
            z = (r == 16'h0);
        end else if (o == 2'b01) begin
            r = 16'((ua - ub + 256) % 256);
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 127) || (s < -128);
            z = (r == 16'h0);
`ifdef CALC_MUL_EN
        end else if (o == 2'b10) begin
            r = 16'(ua * ub);
            z = (r == 16'h0);
`endif
        end else begin
            e = 1'b1;
        end
        return {e, z, v, c, r};
    endfunction

    function automatic int latency(input logic [1:0] o);
`ifdef CALC_MUL_EN
        if (o == 2'b10) return 9;
`endif
        return 2;
    endfunction

    task automatic check_outputs(input string tag, input logic [19:0] exp);
        check({tag, ".result"},   32'(result),   32'(exp[15:0]));
        check({tag, ".carry"},    32'(carry),    32'(exp[16]));
        check({tag, ".overflow"}, 32'(overflow), 32'(exp[17]));
        check({tag, ".zero"},     32'(zero),     32'(exp[18]));
        check({tag, ".err"},      32'(err),      32'(exp[19]));
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int hold);
        logic [19:0] exp;
        int cnt;
        exp = model(o, a, b);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; opa = a; opb = b; out_ready = 1'b0;
        @(posedge clk);
        #1;
        // Garbage on the inputs while busy must not disturb the operation
        op = 2'($urandom); opa = 8'($urandom); opb = 8'($urandom);
        in_valid = 1'($urandom);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                if (o == 2'b00) begin
                    check({tag, ".exec_a"}, 32'({add_a, add_b, add_cin}), 32'({a, b, 1'b0}));
                end else if (o == 2'b01) begin
                    check({tag, ".exec_a"}, 32'({add_a, add_b, add_cin}), 32'({a, ~b, 1'b1}));
`ifdef CALC_MUL_EN
                end else if (o == 2'b10) begin
                    check({tag, ".mul_a"}, 32'({add_a, add_b, add_cin}),
                          32'({8'h00, (b[0] ? a : 8'h00), 1'b0}));
`endif
                end
            end
        end while (!out_valid && cnt < 20);
        check({tag, ".latency"}, 32'(cnt), 32'(latency(o)));
        check({tag, ".done_in_ready"}, 32'(in_ready), 32'd0);
        check_outputs(tag, exp);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check({tag, ".hold"}, 32'({out_valid, in_ready, add_a, add_b, add_cin, result,
                                       carry, overflow, zero, err}),
                  32'({1'b1, 1'b0, 17'h0, exp[15:0], exp[16], exp[17], exp[18], exp[19]}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".release"}, 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
    endtask

    task automatic reset_mid_op();
        logic [1:0] o;
        int k;
        int seen;
`ifdef CALC_MUL_EN
        o = 2'b10; k = 4;
`else
        o = 2'b00; k = 1;
`endif
        in_valid = 1'b1; op = o; opa = 8'hFF; opb = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (k) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid.flags", 32'({out_valid, in_ready, result, carry, overflow, zero, err}),
              32'({1'b0, 1'b1, 16'h0, 4'h0}));
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("rst_mid.no_output", 32'(seen), 32'd0);
        run_op("rst_mid.add", 2'b00, 8'd3, 8'd4, 0);
    endtask

    initial begin
        logic [7:0] corners [4];
        logic [7:0] a, b;
        int seen;
        corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h80; corners[3] = 8'h7F;

        // Requests offered during reset must be dropped
        in_valid = 1'b1; op = 2'b00; opa = 8'h12; opb = 8'h34;
        repeat (3) @(negedge clk);
        check("reset.state", 32'({out_valid, result, carry, overflow, zero, err, add_a, add_b, add_cin}),
              32'h0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("reset.no_accept", 32'(seen), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);

        run_op("add_ff_01", 2'b00, 8'hFF, 8'h01, 0);
        run_op("sub_50_70", 2'b01, 8'h50, 8'h70, 1);
        run_op("add_7f_01", 2'b00, 8'h7F, 8'h01, 0);
        run_op("mul_ff_ff", 2'b10, 8'hFF, 8'hFF, 0);
        run_op("hold5",     2'b01, 8'h80, 8'h01, 5);
        run_op("reserved",  2'b11, 8'h55, 8'hAA, 2);
        reset_mid_op();

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
            run_op($sformatf("rnd%0d", i), 2'($urandom), a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
CALC_OP_SEQUENCER -- requirements
Module: calc_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; only 8 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand/opcode request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 SHALL have port op  input  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-007 SHALL have ports opa and opb  input  8  each, the operands.
REQ-008 SHALL have ports add_a and add_b  output  8  each, driving the external 8-bit ripple adder inputs.
REQ-009 SHALL have port add_cin  output  1  adder carry-in.
REQ-010 SHALL have ports add_sum  input  8  and add_cout  input  1, the adder results, used in the same cycle.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port result  output  16  registered result.
REQ-014 SHALL have ports carry, overflow, zero, err  output  1  each, registered status flags.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, MUL, DONE.
REQ-016 SHALL accept a request when in_valid && in_ready, latching op, opa, opb, and going IDLE->EXEC for op 00/01/11 and IDLE->MUL for op 10.
REQ-017 In EXEC, ADD SHALL drive add_a=opa, add_b=opb, add_cin=0; SUB SHALL drive add_b=~opb, add_cin=1.
REQ-018 EXEC SHALL capture result={8'h00,add_sum}, carry=add_cout, overflow=(add_a[7]==add_b[7])&&(add_sum[7]!=add_a[7]), zero=(add_sum==0), then go to DONE.
REQ-019 For SUB, carry SHALL be 1 when no borrow occurs (opa>=opb unsigned).
REQ-020 Op 11 in EXEC SHALL set err=1, result=0, carry=0, overflow=0, zero=1, then go to DONE; err SHALL be 0 for all other ops.
REQ-021 MUL SHALL use shift-add over exactly 8 cycles with P (8-bit, cleared on accept) and Q=opb: add_a=P, add_b=(Q[0]?opa:0), add_cin=0; then {P,Q}<={add_cout,add_sum,Q[7:1]}.
REQ-022 After the 8th MUL cycle, result SHALL be {P,Q}, carry=0, overflow=0, zero=(result==0), then the FSM SHALL go to DONE.
REQ-023 In states other than EXEC/MUL, add_a, add_b and add_cin SHALL be 0.
REQ-024 out_valid SHALL be high exactly in DONE; result and flags SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE->IDLE SHALL occur on out_valid && out_ready; in_ready SHALL be 0 in that cycle, so accepts resume the next cycle.
REQ-026 Latency from the accept edge to out_valid high SHALL be 2 cycles for ADD/SUB/reserved and 9 cycles for MUL.
REQ-027 in_valid SHALL be ignored outside IDLE; input changes after accept SHALL NOT affect the operation in flight.

Reset
REQ-028 rst_n low at a clock edge SHALL force IDLE, clear P/Q/latched operands, and set result=0, carry=0, overflow=0, zero=0, err=0, out_valid=0, and adder drives 0.
REQ-029 Reset mid-EXEC/MUL/DONE SHALL abort the operation with no output produced.
REQ-030 in_ready SHALL be 1 from the first edge after reset; requests presented while rst_n is low SHALL NOT be accepted.

Configuration
REQ-031 Macro CALC_MUL_EN defined SHALL include the MUL state and REQ-021/022 behaviour.
REQ-032 Without CALC_MUL_EN, op 10 SHALL be handled as reserved per REQ-020 (err=1, 2-cycle latency), and no MUL state or P/Q logic SHALL exist.

Verification
REQ-033 ADD 8'hFF+8'h01 -> result 16'h0000, carry=1, zero=1, overflow=0, out_valid 2 cycles after accept.
REQ-034 SUB 8'h50-8'h70 -> result 16'h00E0, carry=0, overflow=0; ADD 8'h7F+8'h01 -> result 16'h0080, overflow=1.
REQ-035 MUL 8'hFF*8'hFF (CALC_MUL_EN) -> result 16'hFE01, out_valid 9 cycles after accept; without the macro -> err=1, result=0.
REQ-036 out_ready held low 5 cycles in DONE -> result/flags stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-037 rst_n low at the 4th MUL cycle -> out_valid never asserts for that operation, in_ready=1 after reset, next ADD 3+4 -> result 7.
